// File: rtl/width_converter_8ton_if.sv
// Byte-in / word-out stream bundle for width_converter_8ton.
// Signals:
//   sink_valid_i, sink_data_i[7:0], sink_flush_i  byte side, driven by producer
//   sink_ready_o                                  byte side, driven by converter
//   source_valid_o, source_data_o[Width-1:0],
//   source_bytes_o[CntW-1:0]                      word side, driven by converter
//   source_ready_i                                word side, driven by consumer
// Modports: slave = converter view, master = environment (producer/consumer) view.
interface width_converter_8ton_if #(
  parameter int unsigned Width = 32
);
  localparam int unsigned Bytes = Width / 8;
  localparam int unsigned CntW  = $clog2(Bytes) + 1;

  logic             sink_valid_i;
  logic             sink_ready_o;
  logic [7:0]       sink_data_i;
  logic             sink_flush_i;
  logic             source_valid_o;
  logic             source_ready_i;
  logic [Width-1:0] source_data_o;
  logic [CntW-1:0]  source_bytes_o;

  modport slave (
    input  sink_valid_i, sink_data_i, sink_flush_i, source_ready_i,
    output sink_ready_o, source_valid_o, source_data_o, source_bytes_o
  );

  modport master (
    output sink_valid_i, sink_data_i, sink_flush_i, source_ready_i,
    input  sink_ready_o, source_valid_o, source_data_o, source_bytes_o
  );
endinterface

// File: rtl/width_converter_8ton.sv
// Packs an 8-bit byte stream into little-endian Width-bit words.
// A flush pulse emits a partially filled word; unused upper lanes read zero.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     width_converter_8ton_if.slave (byte sink + word source handshakes)
module width_converter_8ton #(
  parameter int unsigned Width = 32
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  width_converter_8ton_if.slave bus
);
  localparam int unsigned Bytes = Width / 8;
  localparam int unsigned CntW  = $clog2(Bytes) + 1;

  if ((Width % 8) != 0 || Width == 0) begin : g_width_check
    $error("width_converter_8ton: Width (%0d) must be a nonzero multiple of 8", Width);
  end

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  bcnt_q, bcnt_d;

  // State, holding register and byte counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      sreg_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state: fill lanes in FILL, hold the word in OUT until it is taken.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      FILL: begin
        if (bus.sink_valid_i) begin
          for (int unsigned i = 0; i < Bytes; i++) begin
            if (bcnt_q == CntW'(i)) sreg_d[8*i +: 8] = bus.sink_data_i;
          end
          bcnt_d = bcnt_q + CntW'(1);
        end
        // Flush uses the post-update count so a same-cycle byte is included.
        if (bcnt_d == CntW'(Bytes) || (bus.sink_flush_i && bcnt_d != '0)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        // Clearing here keeps unused lanes of the next partial word at zero.
        if (bus.source_ready_i) begin
          state_d = FILL;
          sreg_d  = '0;
          bcnt_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Outputs decode registered state only; no path from source_ready_i.
  assign bus.sink_ready_o   = (state_q == FILL);
  assign bus.source_valid_o = (state_q == OUT);
  assign bus.source_data_o  = sreg_q;
  assign bus.source_bytes_o = (state_q == OUT) ? bcnt_q : '0;
endmodule

// File: doc/width_converter_8ton.md
# width_converter_8toN

Bus width converter from 8-bit to N-bit, where N is a multiple of 8. It sits between the I3C target FSM receive path and the TTI RX queue. It packs bytes received over the bus into N-bit words, little-endian. A flush input emits a partially filled word at end of message.

## Interface
Parameters:
- Width, 32, output word width in bits; must be a multiple of 8 (elaboration-time $error otherwise). Bytes = Width/8, Bytes >= 1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- sink_valid_i  input  1  byte valid from target FSM.
- sink_ready_o  output  1  converter can accept a byte.
- sink_data_i  input  8  byte data.
- sink_flush_i  input  1  single-cycle pulse: end of message, emit the partial word.
- source_valid_o  output  1  packed word available.
- source_ready_i  input  1  RX queue accepts the word.
- source_data_o  output  Width  packed word; unfilled upper bytes are zero.
- source_bytes_o  output  $clog2(Bytes)+1  count of valid bytes in source_data_o (1..Bytes while source_valid_o is high, 0 otherwise).

## Operation
- State: two-state FSM FILL/OUT, holding register sreg[Width-1:0], byte counter bcnt[$clog2(Bytes):0].
- FILL:
  - sink_ready_o=1, source_valid_o=0.
  - On byte accept (sink_valid_i & sink_ready_o), write sreg[8*bcnt +: 8] = sink_data_i and increment bcnt.
  - The first byte of a word lands in bits [7:0].
- FILL->OUT transitions:
  - When the accepted byte makes bcnt == Bytes.
  - When sink_flush_i=1 and the post-update byte count is nonzero.
  - A byte accepted in the same cycle as the flush is included in the emitted word.
- Flush in FILL with bcnt==0 and no byte accepted: ignored, no empty word is produced.
- OUT:
  - sink_ready_o=0, source_valid_o=1, source_data_o=sreg, source_bytes_o=bcnt.
  - Data and count are held stable until the handshake.
  - On source_valid_o & source_ready_i: sreg<=0, bcnt<=0, go to FILL.
- sink_flush_i while in OUT: ignored and not remembered. The target FSM only flushes after its last byte is accepted.
- Unused upper lanes of a partial word read as zero, because sreg is cleared on every word handoff and on reset.
- Width==8 (Bytes==1): every accepted byte goes directly to OUT. Flush has no additional effect.
- Reset (asynchronous, any state, including mid-word): FILL, sreg=0, bcnt=0. Any partial word is discarded.
- Reset values of outputs: sink_ready_o=1, source_valid_o=0, source_data_o=0, source_bytes_o=0.

## Timing
- All outputs are registered-state decodes, with no combinational path from source_ready_i to sink_ready_o. sink_ready_o equals !source_valid_o.
- Latency: source_valid_o rises in the cycle after the last byte is accepted or the flush is sampled.
- Throughput: a full word takes Bytes+1 cycles minimum (Bytes accept cycles plus 1 OUT cycle with source_ready_i=1).
- Backpressure: source_ready_i=0 holds OUT indefinitely, and sink_ready_o stays 0 throughout.
- sink_valid_i may be asserted while sink_ready_o=0. The byte is not taken and the target FSM must hold it.

## Test plan
- Full word, Width=32: bytes 0x11,0x22,0x33,0x44 on consecutive cycles with source_ready_i=1 -> source_data_o=0x44332211, source_bytes_o=4, valid for one cycle, sink_ready_o=0 that cycle only.
- Partial flush: bytes 0xAA,0xBB, then sink_flush_i alone -> word 0x0000BBAA with source_bytes_o=2. A following full word contains no residue from it.
- Flush with byte: 0x01, then 0x02 together with sink_flush_i -> 0x00000201, bytes=2. Flush with bcnt==0 and no byte -> source_valid_o stays 0.
- Backpressure: a full word with source_ready_i=0 for 5 cycles -> data and count stable, sink_ready_o=0, offered bytes not consumed. Release -> handoff, then a new word starts at lane 0.
- Reset mid-word: after 3 bytes, pulse rst_ni low asynchronously -> outputs at reset values immediately. The next 4 bytes form a clean word.
- Width=8 and Width=64 instantiations: byte stream with random valid/ready gaps and flushes -> scoreboard matches packed words and byte counts.
